// File: rtl/alu_pkg.sv
// alu_pkg: shared opcodes and FIFO entry layout
// for the ALU operand-preparation stage.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_NEG  = 3'd2;
  localparam logic [OP_W-1:0] OP_INC  = 3'd3;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd4;
  localparam logic [OP_W-1:0] OP_PASS = 3'd5;

  // Entry layout {op, x, y, cmp, cin}: OP_W, w, w, 1, 1.
  localparam int ENT_CTL_W = 2;

  function automatic int ent_w(input int w);
    return OP_W + 2 * w + ENT_CTL_W;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: maps an ALU opcode onto the
// complementer controls and operand routing.
`timescale 1ns/1ps
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [OP_W-1:0]  o_op,
  output logic [WIDTH-1:0] o_x,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cmp,
  output logic             o_cin,
  output logic             o_illegal
);

  // Per-opcode routing; unknown codes degrade to PASS.
  always_comb begin
    o_op      = i_op;
    o_x       = i_a;
    o_y       = '0;
    o_cmp     = 1'b0;
    o_cin     = 1'b0;
    o_illegal = 1'b0;
    unique case (1'b1)
      (i_op == OP_ADD): begin
        o_x = i_b;
        o_y = i_a;
      end
      (i_op == OP_SUB): begin
        o_x   = i_b;
        o_y   = i_a;
        o_cmp = 1'b1;
        o_cin = 1'b1;
      end
      (i_op == OP_NEG): begin
        o_cmp = 1'b1;
        o_cin = 1'b1;
      end
      (i_op == OP_INC): begin
        o_cin = 1'b1;
      end
      (i_op == OP_NOT): begin
        o_cmp = 1'b1;
      end
      (i_op == OP_PASS): begin
        o_op = OP_PASS;
      end
      default: begin
        o_op      = OP_PASS;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: 2-deep decoded-op FIFO feeding
// the two's-complement unit over valid/ready.
`timescale 1ns/1ps
module alu_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_op,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_y,
  output logic             cmp,
  output logic             cin,
  output logic [7:0]       ill_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cmp;
    logic             cin;
  } ent_t;

  ent_t            r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [7:0]      r_ill_cnt;

  ent_t            w_dec;
  ent_t            w_head;
  logic            w_ill;
  logic            w_push;
  logic            w_pop;

  alu_op_decode #(.WIDTH(WIDTH)) u_dec (
    .i_op      (in_op),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_op      (w_dec.op),
    .o_x       (w_dec.x),
    .o_y       (w_dec.y),
    .o_cmp     (w_dec.cmp),
    .o_cin     (w_dec.cin),
    .o_illegal (w_ill)
  );

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Head comes only from stored state; zeroed when empty.
  assign w_head  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_op  = w_head.op;
  assign out_x   = w_head.x;
  assign out_y   = w_head.y;
  assign cmp     = w_head.cmp;
  assign cin     = w_head.cin;
  assign ill_cnt = r_ill_cnt;

  // Entry storage, written with the decoded op at push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_dec;
    end
  end

  // Pointers wrap naturally; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // Saturating count of accepted illegal opcodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_push && w_ill && r_ill_cnt != 8'hFF) begin
      r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed and stress checks
// of the operand stage against a scoreboard.
`timescale 1ns/1ps
module tb_alu_operand_stage;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic        cmp;
    logic        cin;
    logic [15:0] r;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_op;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic        cmp;
  logic        cin;
  logic [7:0]  ill_cnt;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop = 0;
  int   ill_exp = 0;
  bit   done = 0;

  alu_operand_stage #(.WIDTH(16), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_x     (out_x),
    .out_y     (out_y),
    .cmp       (cmp),
    .cin       (cin),
    .ill_cnt   (ill_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] op,
                              input logic [15:0] x,
                              input logic [15:0] y,
                              input logic c, input logic ci,
                              input logic [15:0] r);
    exp_t e;
    e.op = op; e.x = x; e.y = y;
    e.cmp = c; e.cin = ci; e.r = r;
    return e;
  endfunction

  // Reference decode for the stress phase.
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t e;
    e = '0;
    e.op = op;
    e.x = a;
    case (op)
      3'd0: begin e.x = b; e.y = a; end
      3'd1: begin e.x = b; e.y = a; e.cmp = 1; e.cin = 1; end
      3'd2: begin e.cmp = 1; e.cin = 1; end
      3'd3: e.cin = 1;
      3'd4: e.cmp = 1;
      default: e.op = 3'd5;
    endcase
    e.r = e.cmp ? (~e.x + 16'(e.cin)) : (e.x + 16'(e.cin));
    return e;
  endfunction

  // Monitor: scoreboard pops, hold stability, idle zeros.
  logic [36:0] held;
  bit          stall_prev = 0;
  always @(negedge clk) begin
    logic [36:0] cur;
    logic [15:0] rr;
    exp_t e;
    cur = {out_op, out_x, out_y, cmp, cin};
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("hold_stable", 64'(cur), 64'(held));
      if (!out_valid) chk("idle_zero", 64'(cur), 64'd0);
      if (out_valid && out_ready) begin
        n_pop++;
        if (q.size() == 0) begin
          chk("unexpected_out", 64'(cur), 64'd0);
        end else begin
          e = q.pop_front();
          chk("entry", 64'(cur),
              64'({e.op, e.x, e.y, e.cmp, e.cin}));
          rr = cmp ? (~out_x + 16'(cin)) : (out_x + 16'(cin));
          chk("result_r", 64'(rr), 64'(e.r));
        end
      end
      stall_prev = out_valid && !out_ready;
      held = cur;
    end
  end

  // One-cycle push attempt, called at posedge+2.
  task automatic try_push(input logic [2:0] op,
                          input logic [15:0] a,
                          input logic [15:0] b,
                          input exp_t e, output bit acc);
    in_valid = 1; in_op = op; in_a = a; in_b = b;
    @(negedge clk);
    acc = in_ready;
    if (acc) begin
      q.push_back(e);
      n_push++;
      if (op > 3'd5 && ill_exp != 255) ill_exp++;
    end
    @(posedge clk); #2;
    in_valid = 0;
  endtask

  task automatic push(input logic [2:0] op,
                      input logic [15:0] a,
                      input logic [15:0] b,
                      input exp_t e);
    bit acc;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) begin
      try_push(op, a, b, e, acc);
    end
    if (!acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_empty();
    bit ok;
    ok = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      if (q.size() == 0 && !out_valid) ok = 1;
      else begin @(posedge clk); #2; end
    end
    chk("drain", 64'(ok), 64'd1);
  endtask

  initial begin
    bit acc;
    rst_n = 0; in_valid = 0; in_op = 0;
    in_a = 0; in_b = 0; out_ready = 0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outs", 64'({out_valid, out_op, out_x, out_y, cmp, cin}), 64'd0);
    chk("rst_ill", 64'(ill_cnt), 64'd0);
    @(posedge clk); #2;
    rst_n = 1;

    // SUB 5 - 3 -> x=3 y=5, R=~3+1=FFFD
    out_ready = 1;
    push(3'd1, 16'h0005, 16'h0003,
         mk(3'd1, 16'h0003, 16'h0005, 1, 1, 16'hFFFD));
    chk("latency_sub", 64'(out_valid), 64'd1);
    wait_empty();

    // NEG 8000 then INC FFFF back-to-back
    push(3'd2, 16'h8000, 16'h0000,
         mk(3'd2, 16'h8000, 16'h0000, 1, 1, 16'h8000));
    push(3'd3, 16'hFFFF, 16'h0000,
         mk(3'd3, 16'hFFFF, 16'h0000, 0, 1, 16'h0000));
    wait_empty();

    // Stall: fill, refuse third, drain in order
    out_ready = 0;
    try_push(3'd0, 16'h0001, 16'h0002,
             mk(3'd0, 16'h0002, 16'h0001, 0, 0, 16'h0002), acc);
    chk("fill_acc1", 64'(acc), 64'd1);
    try_push(3'd1, 16'h000A, 16'h0004,
             mk(3'd1, 16'h0004, 16'h000A, 1, 1, 16'hFFFC), acc);
    chk("fill_acc2", 64'(acc), 64'd1);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    try_push(3'd5, 16'h0077, 16'h0000,
             mk(3'd5, 16'h0077, 16'h0000, 0, 0, 16'h0077), acc);
    chk("full_refuse", 64'(acc), 64'd0);
    repeat (2) begin @(posedge clk); #2; end
    out_ready = 1;
    @(posedge clk); #1;
    chk("ready_after_pop", 64'(in_ready), 64'd1);
    #1;
    wait_empty();

    // 300 illegal opcodes: PASS decode, counter saturates
    for (int i = 0; i < 300; i++) begin
      push(3'd7, 16'h1234, 16'h5555,
           mk(3'd5, 16'h1234, 16'h0000, 0, 0, 16'h1234));
    end
    wait_empty();
    chk("ill_sat", 64'(ill_cnt), 64'd255);

    // Async reset with two entries held
    out_ready = 0;
    push(3'd0, 16'h0003, 16'h0004,
         mk(3'd0, 16'h0004, 16'h0003, 0, 0, 16'h0004));
    push(3'd4, 16'h00FF, 16'h0000,
         mk(3'd4, 16'h00FF, 16'h0000, 1, 0, 16'hFF00));
    chk("two_held", 64'(in_ready), 64'd0);
    #1;
    rst_n = 0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_outs", 64'({out_op, out_x, out_y, cmp, cin}), 64'd0);
    chk("arst_ill", 64'(ill_cnt), 64'd0);
    q.delete();
    ill_exp = 0;
    @(posedge clk); #2;
    rst_n = 1;
    out_ready = 1;
    push(3'd0, 16'h1000, 16'h0234,
         mk(3'd0, 16'h0234, 16'h1000, 0, 0, 16'h0234));
    chk("latency_add", 64'(out_valid), 64'd1);
    wait_empty();

    // Random valid/ready stress
    n_push = 0;
    n_pop = 0;
    fork
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [2:0]  op;
          logic [15:0] a;
          logic [15:0] b;
          op = 3'($urandom_range(0, 7));
          a = 16'($urandom);
          b = 16'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #2;
          end
          push(op, a, b, model(op, a, b));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #2;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1;
    wait_empty();
    chk("stress_count", 64'(n_pop), 64'(n_push));
    chk("stress_ops", 64'(n_push), 64'd10000);
    chk("stress_ill", 64'(ill_cnt), 64'(ill_exp));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
